i2c_bus_scheduler: RTL and testbench
====================================

Name: i2c_bus_scheduler

Overview:
- Shares the single multi-master I2C SCL clock generator between NUM_REQ internal requesters, such as a config engine and a telemetry poller.
- Tracks bus busy/free state from the sampled SCL/SDA lines and enforces the bus-free time before any grant.
- Round-robin arbitration between requesters.
- Gates the clock generator's enable input, and aborts the current owner when the clock generator reports bus_clear (SCL held low).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BUS_FREE_CYCLES, 3, clk_in cycles SCL=SDA=1 with the bus idle before a grant may issue (tBUF).
- HOLD_TIMEOUT, 1000, maximum GRANTED cycles; used only with ARB_HOLD_TIMEOUT_EN.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL line level.
- sda_in  input  1  raw SDA line level.
- bus_clear  input  1  from clock generator; SCL stuck low.
- req  input  NUM_REQ  request, held high for the whole transaction.
- grant  output  NUM_REQ  one-hot grant, registered.
- clock_enable  output  1  enables the SCL clock generator; high only in GRANTED.
- bus_busy  output  1  START seen, STOP not yet seen.
- abort  output  1  one-cycle pulse when a grant is revoked.
- abort_id  output  $clog2(NUM_REQ)  index of the revoked owner; valid on abort.

Behaviour:
- Synchronisation:
  - scl_in and sda_in pass through a 2-flop synchroniser, then one history flop: scl_q/sda_q and scl_p/sda_p.
  - Line-to-detect latency is 3 cycles.
- START/STOP detection:
  - START = scl_p & scl_q & sda_p & !sda_q. STOP = scl_p & scl_q & !sda_p & sda_q.
  - bus_busy is set on START and cleared on STOP.
  - If both are seen in the same cycle (impossible on a legal bus), STOP wins.
- Free counter:
  - Increments while !bus_busy & scl_q & sda_q; otherwise clears to 0.
  - Saturates at BUS_FREE_CYCLES. bus_free = (count == BUS_FREE_CYCLES).
- Winner selection: the first set req bit at or above ptr, wrapping modulo NUM_REQ. ptr resets to 0.
- FSM states: IDLE, WAIT_FREE, GRANTED, ABORT.
  - IDLE: if |req, go to WAIT_FREE next cycle.
  - WAIT_FREE:
    - If req == 0, go to IDLE.
    - Else if bus_free and !bus_clear, go to GRANTED. The winner is latched into owner, and grant[owner] = 1 from the first GRANTED cycle.
  - GRANTED:
    - clock_enable = 1; grant is stable and changes for no other request.
    - If bus_clear, go to ABORT.
    - Else if req[owner] == 0, go to IDLE, with ptr = owner+1 mod NUM_REQ, grant = 0 and clock_enable = 0 in the IDLE cycle.
  - ABORT:
    - Entry cycle: abort = 1, abort_id = owner, grant = 0, clock_enable = 0, ptr = owner+1.
    - Stays in ABORT until bus_clear == 0 and req[owner] == 0, then goes to IDLE.
- Simultaneous events:
  - bus_clear and owner req drop in the same cycle: ABORT wins.
  - Multiple requesters: exactly one grant bit is ever high.
  - A req change of a non-owner during GRANTED has no effect.
- bus_clear in IDLE or WAIT_FREE: no state change; the counter is held at 0 by low SCL, so no grant issues.
- Reset values, applied the cycle after reset is sampled high, including mid-GRANTED:
  - Outputs: grant = 0, clock_enable = 0, abort = 0, abort_id = 0, bus_busy = 0.
  - Internal: state = IDLE, count = 0, ptr = 0.
  - Synchroniser flops reset to 1 (idle bus).

Optional Feature:
- ARB_HOLD_TIMEOUT_EN defined:
  - A hold counter clears on entry to GRANTED and increments each GRANTED cycle.
  - When it reaches HOLD_TIMEOUT, the FSM goes to ABORT with an identical abort/abort_id pulse.
- Not defined: no hold counter exists, and a grant is held indefinitely while req[owner] = 1.

Test Plan:
- Single request, idle bus:
  - Stimulus: req = 01 with SCL = SDA = 1 from reset.
  - Required: grant = 01 and clock_enable = 1 by cycle 3 + BUS_FREE_CYCLES + 2 (8 for defaults). Dropping req[0] gives grant = 00 one cycle later.
- Round robin:
  - Stimulus: req = 11 held. Owner 0 releases and re-requests.
  - Required: next grant = 10, then 01. Never both bits high.
- Foreign master:
  - Stimulus: drive START (SDA falls, SCL = 1), then req = 01.
  - Required: bus_busy = 1 and no grant. After STOP, grant arrives exactly BUS_FREE_CYCLES + 1 cycles after bus_busy clears.
- Bus clear:
  - Stimulus: in GRANTED with owner 1, assert bus_clear.
  - Required: next cycle abort = 1 for 1 cycle, abort_id = 1, grant = 00, clock_enable = 0. The FSM stays in ABORT until bus_clear = 0 and req[1] = 0.
- Reset mid-transaction:
  - Stimulus: assert reset for 1 cycle while GRANTED.
  - Required: all outputs 0 next cycle. After release, owner 0 wins a 11 request.
- Timeout (ARB_HOLD_TIMEOUT_EN, HOLD_TIMEOUT = 20):
  - Stimulus: hold req = 01.
  - Required: abort pulse after 20 GRANTED cycles with abort_id = 0. Without the macro, no abort after 100 cycles.

Source files
------------

// File: rtl/i2c_bus_scheduler.sv
// i2c_bus_scheduler: round-robin sharing of one multi-master I2C clock generator
// between NUM_REQ internal requesters, gated by observed bus busy/free state.
// Optional hold timeout compiled in with `define ARB_HOLD_TIMEOUT_EN.
module i2c_bus_scheduler #(
  parameter int NUM_REQ         = 2,
  parameter int BUS_FREE_CYCLES = 3,
  parameter int HOLD_TIMEOUT    = 1000
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       scl_in,
  input  logic                       sda_in,
  input  logic                       bus_clear,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       clock_enable,
  output logic                       bus_busy,
  output logic                       abort,
  output logic [$clog2(NUM_REQ)-1:0] abort_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUS_FREE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FREE,
    S_GRANTED,
    S_ABORT
  } state_t;

  // line synchroniser and history flops
  logic          r_scl_s1, r_scl_q, r_scl_p;
  logic          r_sda_s1, r_sda_q, r_sda_p;
  // bus observation
  logic          r_bus_busy;
  logic [CW-1:0] r_count;
  // arbitration state
  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_clock_enable;
  logic                 r_abort;
  logic [IW-1:0]        r_abort_id;

  logic          w_start;
  logic          w_stop;
  logic          w_bus_free;
  logic [IW-1:0] w_winner;
  logic          w_found;
  int            w_idx;
  logic [IW-1:0] w_owner_next;
  logic          w_hold_expired;

  assign w_start    = r_scl_p & r_scl_q &  r_sda_p & ~r_sda_q;
  assign w_stop     = r_scl_p & r_scl_q & ~r_sda_p &  r_sda_q;
  assign w_bus_free = (r_count == CW'(BUS_FREE_CYCLES));

  // pointer the released/revoked owner hands on to, wrapping at NUM_REQ
  assign w_owner_next = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // two-flop synchroniser plus one history stage; idle-bus reset value
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_q  <= 1'b1;
      r_scl_p  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_q  <= 1'b1;
      r_sda_p  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_q  <= r_scl_s1;
      r_scl_p  <= r_scl_q;
      r_sda_s1 <= sda_in;
      r_sda_q  <= r_sda_s1;
      r_sda_p  <= r_sda_q;
    end
  end

  // busy flag from START/STOP (STOP dominates) and saturating bus-free timer
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_bus_busy <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_stop)
        r_bus_busy <= 1'b0;
      else if (w_start)
        r_bus_busy <= 1'b1;

      if (!r_bus_busy && r_scl_q && r_sda_q) begin
        if (!w_bus_free)
          r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
    end
  end

  // round-robin pick: first requester at or after r_ptr, wrapping
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ)
        w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  logic [HW-1:0] r_hold;

  assign w_hold_expired = (r_state == S_GRANTED) && (r_hold == HW'(HOLD_TIMEOUT - 1));

  // counts GRANTED cycles; zero on the first GRANTED cycle of every grant
  always_ff @(posedge clk_in) begin
    if (reset)
      r_hold <= '0;
    else if (r_state != S_GRANTED)
      r_hold <= '0;
    else
      r_hold <= r_hold + 1'b1;
  end
`else
  // without the timer a grant lasts as long as the owner keeps requesting
  logic w_unused_hold_cfg;
  assign w_unused_hold_cfg = (HOLD_TIMEOUT > 0);
  assign w_hold_expired    = 1'b0;
`endif

  // arbitration FSM with registered grant/enable/abort outputs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_owner        <= '0;
      r_grant        <= '0;
      r_clock_enable <= 1'b0;
      r_abort        <= 1'b0;
      r_abort_id     <= '0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req)
            r_state <= S_WAIT_FREE;
        end
        S_WAIT_FREE: begin
          if (req == '0) begin
            r_state <= S_IDLE;
          end else if (w_bus_free && !bus_clear) begin
            r_state        <= S_GRANTED;
            r_owner        <= w_winner;
            r_grant        <= NUM_REQ'(1) << w_winner;
            r_clock_enable <= 1'b1;
          end
        end
        S_GRANTED: begin
          // revocation outranks a simultaneous voluntary release
          if (bus_clear || w_hold_expired) begin
            r_state        <= S_ABORT;
            r_abort        <= 1'b1;
            r_abort_id     <= r_owner;
            r_grant        <= '0;
            r_clock_enable <= 1'b0;
            r_ptr          <= w_owner_next;
          end else if (!req[r_owner]) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_clock_enable <= 1'b0;
            r_ptr          <= w_owner_next;
          end
        end
        S_ABORT: begin
          // wait for the line to recover and the revoked owner to let go
          if (!bus_clear && !req[r_owner])
            r_state <= S_IDLE;
        end
        default: begin
          r_state        <= S_IDLE;
          r_grant        <= '0;
          r_clock_enable <= 1'b0;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign clock_enable = r_clock_enable;
  assign bus_busy     = r_bus_busy;
  assign abort        = r_abort;
  assign abort_id     = r_abort_id;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench for i2c_bus_scheduler with default parameters
// (NUM_REQ=2, BUS_FREE_CYCLES=3, timeout feature not compiled in).
module tb_i2c_bus_scheduler;

  logic       clk_in;
  logic       reset;
  logic       scl_in;
  logic       sda_in;
  logic       bus_clear;
  logic [1:0] req;
  logic [1:0] grant;
  logic       clock_enable;
  logic       bus_busy;
  logic       abort;
  logic [0:0] abort_id;

  int total;
  int bad;
  int n;
  logic abort_seen;

  i2c_bus_scheduler #(
    .NUM_REQ        (2),
    .BUS_FREE_CYCLES(3),
    .HOLD_TIMEOUT   (1000)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .bus_clear   (bus_clear),
    .req         (req),
    .grant       (grant),
    .clock_enable(clock_enable),
    .bus_busy    (bus_busy),
    .abort       (abort),
    .abort_id    (abort_id)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bounded wait for any grant bit
  task automatic wait_grant(input int limit, output int cycles);
    cycles = 0;
    while (grant == 2'b00 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    abort_seen = 1'b0;
    reset = 1'b1;
    scl_in = 1'b1;
    sda_in = 1'b1;
    bus_clear = 1'b0;
    req = 2'b00;
    tick();
    tick();

    // reset state
    chk("rst_grant", 32'(grant), 0);
    chk("rst_clock_enable", 32'(clock_enable), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_abort_id", 32'(abort_id), 0);
    chk("rst_bus_busy", 32'(bus_busy), 0);

    // single request on an idle bus: grant within 3+BUS_FREE_CYCLES+2 cycles
    reset = 1'b0;
    req = 2'b01;
    wait_grant(8, n);
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_clock_enable", 32'(clock_enable), 1);
    req = 2'b00;
    tick();
    chk("single_release_grant", 32'(grant), 0);
    chk("single_release_ce", 32'(clock_enable), 0);

    // round robin: pointer now 1 after owner 0 released
    req = 2'b11;
    wait_grant(8, n);
    chk("rr_first", 32'(grant), 32'h2);
    req = 2'b01;
    tick();
    chk("rr_release_owner1", 32'(grant), 0);
    req = 2'b11;
    wait_grant(8, n);
    chk("rr_second", 32'(grant), 32'h1);
    // non-owner dropping and re-raising its request changes nothing
    req = 2'b01;
    tick();
    tick();
    tick();
    chk("rr_nonowner_drop", 32'(grant), 32'h1);
    chk("rr_nonowner_ce", 32'(clock_enable), 1);
    req = 2'b11;
    tick();
    chk("rr_nonowner_rise", 32'(grant), 32'h1);
    req = 2'b10;
    tick();
    chk("rr_release_owner0", 32'(grant), 0);
    req = 2'b11;
    wait_grant(8, n);
    chk("rr_third", 32'(grant), 32'h2);
    req = 2'b00;
    tick();
    chk("rr_idle", 32'(grant), 0);

    // foreign master: START seen 3 cycles after SDA falls with SCL high
    sda_in = 1'b0;
    tick();
    tick();
    chk("start_not_yet", 32'(bus_busy), 0);
    tick();
    chk("start_busy", 32'(bus_busy), 1);
    req = 2'b01;
    repeat (10) tick();
    chk("busy_no_grant", 32'(grant), 0);
    chk("busy_still", 32'(bus_busy), 1);
    // STOP: busy clears after 3 cycles, grant exactly 4 cycles later
    sda_in = 1'b1;
    tick();
    tick();
    tick();
    chk("stop_busy_clear", 32'(bus_busy), 0);
    chk("stop_no_grant_yet", 32'(grant), 0);
    tick();
    tick();
    tick();
    chk("stop_tbuf_early", 32'(grant), 0);
    tick();
    chk("stop_tbuf_grant", 32'(grant), 32'h1);

    // bus clear while owner 1 holds the grant
    req = 2'b00;
    tick();
    req = 2'b10;
    wait_grant(8, n);
    chk("clr_owner1_grant", 32'(grant), 32'h2);
    bus_clear = 1'b1;
    tick();
    chk("clr_abort", 32'(abort), 1);
    chk("clr_abort_id", 32'(abort_id), 1);
    chk("clr_grant", 32'(grant), 0);
    chk("clr_clock_enable", 32'(clock_enable), 0);
    tick();
    chk("clr_abort_pulse", 32'(abort), 0);
    bus_clear = 1'b0;
    repeat (6) tick();
    chk("clr_stay_abort", 32'(grant), 0);
    req = 2'b00;
    tick();
    // pointer moved to owner+1 = 0 on abort
    req = 2'b11;
    wait_grant(8, n);
    chk("clr_ptr_next", 32'(grant), 32'h1);

    // reset while owner 1 is granted (pointer 1 before reset)
    req = 2'b00;
    tick();
    req = 2'b10;
    wait_grant(8, n);
    chk("mid_owner1_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    req = 2'b11;
    tick();
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_ce", 32'(clock_enable), 0);
    chk("mid_rst_abort", 32'(abort), 0);
    chk("mid_rst_abort_id", 32'(abort_id), 0);
    chk("mid_rst_busy", 32'(bus_busy), 0);
    reset = 1'b0;
    wait_grant(8, n);
    chk("mid_rst_owner0_wins", 32'(grant), 32'h1);

    // without the timeout feature a held grant is never revoked
    req = 2'b01;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (abort)
        abort_seen = 1'b1;
    end
    chk("no_timeout_abort", 32'(abort_seen), 0);
    chk("no_timeout_grant", 32'(grant), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
